dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer putting a core port (A) and a debug/DMA port (B) onto one data memory.
// Define DMEM_ADDR_CHECK_EN to suppress and flag accesses whose address is at or beyond Depth.
module dmem_arbiter #(
  parameter int Width    = 32,
  parameter int AD_Width = 32,
  parameter int Depth    = 128
) (
  input  logic                clk,
  input  logic                Res,
  input  logic                A_Req,
  input  logic                A_Wr,
  input  logic [AD_Width-1:0] A_Addr,
  input  logic [Width-1:0]    A_WData,
  output logic                A_Gnt,
  output logic [Width-1:0]    A_RData,
  output logic                A_RValid,
  input  logic                B_Req,
  input  logic                B_Wr,
  input  logic [AD_Width-1:0] B_Addr,
  input  logic [Width-1:0]    B_WData,
  output logic                B_Gnt,
  output logic [Width-1:0]    B_RData,
  output logic                B_RValid,
  output logic [AD_Width-1:0] Mem_Addr,
  output logic [Width-1:0]    Mem_WData,
  output logic                Mem_WrEn,
  input  logic [Width-1:0]    Mem_RData,
  output logic                Busy,
  output logic                Addr_Err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

`ifdef DMEM_ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_b;
  logic [AD_Width-1:0]   r_cmd_addr;
  logic [Width-1:0]      r_cmd_wdata;
  logic                  r_cmd_wr;
  logic                  r_cmd_b;
  logic                  r_cmd_err;
  logic                  r_a_gnt;
  logic                  r_b_gnt;
  logic                  r_busy;
  logic                  r_wren;
  logic                  r_addr_err;
  logic [Width-1:0]      r_a_rdata;
  logic                  r_a_rvalid;
  logic [Width-1:0]      r_b_rdata;
  logic                  r_b_rvalid;

  logic                  w_take;
  logic                  w_win_b;
  logic [AD_Width-1:0]   w_win_addr;
  logic [Width-1:0]      w_win_wdata;
  logic                  w_win_wr;
  logic                  w_range_err;
  logic [Width-1:0]      w_rd_data;

  // Next-state and winner selection; on a tie the requester not granted last time wins
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_win_b     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (A_Req || B_Req) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ACCESS;
          if (A_Req && B_Req) begin
            w_win_b = ~r_last_b;
          end else begin
            w_win_b = B_Req;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command fields of the selected requester
  always_comb begin
    w_win_addr  = A_Addr;
    w_win_wdata = A_WData;
    w_win_wr    = A_Wr;
    if (w_win_b) begin
      w_win_addr  = B_Addr;
      w_win_wdata = B_WData;
      w_win_wr    = B_Wr;
    end else begin
      w_win_addr  = A_Addr;
      w_win_wdata = A_WData;
      w_win_wr    = A_Wr;
    end
  end

  assign w_range_err = CHECK_EN & (w_win_addr >= AD_Width'(Depth));
  assign w_rd_data   = r_cmd_err ? {Width{1'b0}} : Mem_RData;

  // State register
  always_ff @(posedge clk or negedge Res) begin
    if (!Res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command register and round-robin pointer, loaded when a request is accepted
  always_ff @(posedge clk or negedge Res) begin
    if (!Res) begin
      r_last_b    <= 1'b1;
      r_cmd_addr  <= {AD_Width{1'b0}};
      r_cmd_wdata <= {Width{1'b0}};
      r_cmd_wr    <= 1'b0;
      r_cmd_b     <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else if (w_take) begin
      r_last_b    <= w_win_b;
      r_cmd_addr  <= w_win_addr;
      r_cmd_wdata <= w_win_wdata;
      r_cmd_wr    <= w_win_wr;
      r_cmd_b     <= w_win_b;
      r_cmd_err   <= w_range_err;
    end
  end

  // ACCESS-cycle strobes, registered so they are one-cycle pulses aligned with the command
  always_ff @(posedge clk or negedge Res) begin
    if (!Res) begin
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_busy     <= 1'b0;
      r_wren     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_a_gnt    <= w_take & ~w_win_b;
      r_b_gnt    <= w_take & w_win_b;
      r_busy     <= w_take;
      r_wren     <= w_take & w_win_wr & ~w_range_err;
      r_addr_err <= w_take & w_range_err;
    end
  end

  // Read response capture at the end of ACCESS; the other requester's data is left alone
  always_ff @(posedge clk or negedge Res) begin
    if (!Res) begin
      r_a_rdata  <= {Width{1'b0}};
      r_a_rvalid <= 1'b0;
      r_b_rdata  <= {Width{1'b0}};
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if ((r_state == ST_ACCESS) && !r_cmd_wr) begin
        if (r_cmd_b) begin
          r_b_rdata  <= w_rd_data;
          r_b_rvalid <= 1'b1;
        end else begin
          r_a_rdata  <= w_rd_data;
          r_a_rvalid <= 1'b1;
        end
      end
    end
  end

  assign A_Gnt     = r_a_gnt;
  assign B_Gnt     = r_b_gnt;
  assign Busy      = r_busy;
  assign Mem_WrEn  = r_wren;
  assign Mem_Addr  = r_cmd_addr;
  assign Mem_WData = r_cmd_wdata;
  assign Addr_Err  = r_addr_err;
  assign A_RData   = r_a_rdata;
  assign A_RValid  = r_a_rvalid;
  assign B_RData   = r_b_rdata;
  assign B_RValid  = r_b_rvalid;

endmodule
